// File: rtl/dh_sched.sv
// dh_sched: walks the NUM_COL x 8 channel matrix, feeds the |H|^2 accumulator, writes Dh per column.
// Optional minimum-Dh tracker enabled by defining DH_SCHED_MIN_EN.
module dh_sched #(
  parameter int Q       = 8,
  parameter int N       = 16,
  parameter int NUM_COL = 4,
  parameter int COL_W   = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
  parameter int ADDR_W  = COL_W + 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_h_rd,
  output logic [ADDR_W-1:0] o_h_addr,
  input  logic [N-1:0]      i_h_real,
  input  logic [N-1:0]      i_h_im,
  output logic              o_acc_en,
  output logic [N-1:0]      o_acc_real,
  output logic [N-1:0]      o_acc_im,
  input  logic [N-1:0]      i_acc_result,
  input  logic              i_acc_valid,
  output logic              o_dh_wr,
  output logic [COL_W-1:0]  o_dh_idx,
  output logic [N-1:0]      o_dh_val,
  output logic [COL_W-1:0]  o_min_idx,
  output logic [N-1:0]      o_min_val,
  output logic              o_min_valid
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_READ | issuing the 8 row reads of the current column
  // S_WAIT | waiting for the accumulator result of the current column
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT} state_t;

  if (NUM_COL < 1 || NUM_COL > 16 || Q >= N) begin : g_param_check
    $error("dh_sched: parameter out of range");
  end

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL - 1);

  state_t              r_state, w_state_d;
  logic [COL_W-1:0]    r_col, w_col_d, w_col_inc;
  logic [2:0]          r_row, w_row_d;
  logic                r_h_rd, w_rd_d;
  logic [ADDR_W-1:0]   r_h_addr, w_addr_d;
  logic                r_rd_d1, r_acc_en;
  logic [N-1:0]        r_acc_real, r_acc_im;
  logic                r_dh_wr, w_wr_d;
  logic [COL_W-1:0]    r_dh_idx;
  logic [N-1:0]        r_dh_val;
  logic                r_done, w_done_d;
  logic                r_err, w_err_d;
  logic                w_accept;

  assign w_col_inc = r_col + COL_W'(1);

  always_comb begin
    w_state_d = r_state;
    w_col_d   = r_col;
    w_row_d   = r_row;
    w_rd_d    = 1'b0;
    w_addr_d  = r_h_addr;
    w_wr_d    = 1'b0;
    w_done_d  = 1'b0;
    w_err_d   = r_err;
    w_accept  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          // First read goes out on the accepting edge so h_rd appears one cycle later.
          w_accept  = 1'b1;
          w_err_d   = 1'b0;
          w_col_d   = '0;
          w_row_d   = 3'd1;
          w_rd_d    = 1'b1;
          w_addr_d  = {{COL_W{1'b0}}, 3'd0};
          w_state_d = S_READ;
        end else if (i_acc_valid) begin
          w_err_d = 1'b1;
        end
      end
      S_READ: begin
        w_rd_d   = 1'b1;
        w_addr_d = {r_col, r_row};
        w_row_d  = r_row + 3'd1;
        if (r_row == 3'd7) w_state_d = S_WAIT;
        if (i_acc_valid) w_err_d = 1'b1;
      end
      S_WAIT: begin
        if (i_acc_valid) begin
          w_wr_d = 1'b1;
          if (r_col == LAST_COL) begin
            w_done_d  = 1'b1;
            w_state_d = S_IDLE;
          end else begin
            w_col_d   = w_col_inc;
            w_row_d   = 3'd1;
            w_rd_d    = 1'b1;
            w_addr_d  = {w_col_inc, 3'd0};
            w_state_d = S_READ;
          end
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_h_rd     <= 1'b0;
      r_h_addr   <= '0;
      r_rd_d1    <= 1'b0;
      r_acc_en   <= 1'b0;
      r_acc_real <= '0;
      r_acc_im   <= '0;
      r_dh_wr    <= 1'b0;
      r_dh_idx   <= '0;
      r_dh_val   <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_col    <= w_col_d;
      r_row    <= w_row_d;
      r_h_rd   <= w_rd_d;
      r_h_addr <= w_addr_d;
      r_rd_d1  <= r_h_rd;
      r_acc_en <= r_rd_d1;
      if (r_rd_d1) begin
        r_acc_real <= i_h_real;
        r_acc_im   <= i_h_im;
      end
      r_dh_wr <= w_wr_d;
      if (w_wr_d) begin
        r_dh_idx <= r_col;
        r_dh_val <= i_acc_result;
      end
      r_done <= w_done_d;
      r_err  <= w_err_d;
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_h_rd     = r_h_rd;
  assign o_h_addr   = r_h_addr;
  assign o_acc_en   = r_acc_en;
  assign o_acc_real = r_acc_real;
  assign o_acc_im   = r_acc_im;
  assign o_dh_wr    = r_dh_wr;
  assign o_dh_idx   = r_dh_idx;
  assign o_dh_val   = r_dh_val;

`ifdef DH_SCHED_MIN_EN
  logic             r_min_first;
  logic [COL_W-1:0] r_min_idx;
  logic [N-1:0]     r_min_val;
  logic             r_min_valid;

  // Compare against the incoming result so the last column is folded in by the done cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_min_first <= 1'b0;
      r_min_idx   <= '0;
      r_min_val   <= '0;
      r_min_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_min_first <= 1'b1;
        r_min_valid <= 1'b0;
      end
      if (w_wr_d && (r_min_first || ($signed(i_acc_result) < $signed(r_min_val)))) begin
        r_min_idx   <= r_col;
        r_min_val   <= i_acc_result;
        r_min_first <= 1'b0;
      end
      if (w_done_d) r_min_valid <= 1'b1;
    end
  end

  assign o_min_idx   = r_min_idx;
  assign o_min_val   = r_min_val;
  assign o_min_valid = r_min_valid;
`else
  assign o_min_idx   = '0;
  assign o_min_val   = '0;
  assign o_min_valid = 1'b0;
`endif

endmodule
